// File: rtl/hazard3_ahbl_arbiter.sv
// N-port AHB-Lite arbiter: merges core-side request ports onto one AHB-Lite master port.
// Grant is combinational. A stalled NSEQ holds the winner. Write data follows the data-phase owner.
module hazard3_ahbl_arbiter #(
    parameter int N_PORTS     = 2,
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int ROUND_ROBIN = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic [N_PORTS-1:0]          src_aph_req,
    input  logic [N_PORTS-1:0]          src_aph_panic,
    input  logic [N_PORTS-1:0]          src_aph_excl,
    input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
    input  logic [N_PORTS*3-1:0]        src_hsize,
    input  logic [N_PORTS-1:0]          src_hwrite,
    input  logic [N_PORTS*4-1:0]        src_hprot,
    input  logic [N_PORTS*W_DATA-1:0]   src_wdata,
    output logic [N_PORTS-1:0]          src_aph_ready,
    output logic [N_PORTS-1:0]          src_dph_ready,
    output logic [N_PORTS-1:0]          src_dph_err,
    output logic [N_PORTS-1:0]          src_dph_exokay,
    output logic [W_DATA-1:0]           src_rdata,

    output logic [W_ADDR-1:0]           ahblm_haddr,
    output logic                        ahblm_hwrite,
    output logic [1:0]                  ahblm_htrans,
    output logic [2:0]                  ahblm_hsize,
    output logic [2:0]                  ahblm_hburst,
    output logic [3:0]                  ahblm_hprot,
    output logic                        ahblm_hmastlock,
    output logic                        ahblm_hexcl,
    input  logic                        ahblm_hready,
    input  logic                        ahblm_hresp,
    input  logic                        ahblm_hexokay,
    output logic [W_DATA-1:0]           ahblm_hwdata,
    input  logic [W_DATA-1:0]           ahblm_hrdata
);

    localparam int W_PTR = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic               hold_q,        hold_d;
    logic               grant_panic_q, grant_panic_d;
    logic [N_PORTS-1:0] grant_q,       grant_d;
    logic [N_PORTS-1:0] dph_owner_q,   dph_owner_d;
    logic [W_PTR-1:0]   rr_ptr_q,      rr_ptr_d;

    logic [N_PORTS-1:0] grant;
    logic               grant_panic;
    logic [W_PTR-1:0]   grant_idx;
    logic [N_PORTS-1:0] rr_req_rot;
    logic [N_PORTS-1:0] rr_gnt_rot;

    function automatic logic [N_PORTS-1:0] lowest_one(input logic [N_PORTS-1:0] v);
        return v & (~v + N_PORTS'(1));
    endfunction

    // Round-robin: rotate requests so rr_ptr sits at bit 0, pick lowest, rotate back.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rr_req_rot  = N_PORTS'({src_aph_req, src_aph_req} >> rr_ptr_q);
        rr_gnt_rot  = lowest_one(rr_req_rot);
        grant       = '0;
        grant_panic = 1'b0;
        if (!rst_n) begin
            grant = '0;
        end else if (hold_q) begin
            grant       = grant_q;
            grant_panic = grant_panic_q;
        end else if (|src_aph_panic) begin
            grant       = lowest_one(src_aph_panic);
            grant_panic = 1'b1;
        end else if (ROUND_ROBIN == 0) begin
            grant = lowest_one(src_aph_req);
        end else begin
            grant = N_PORTS'({rr_gnt_rot, rr_gnt_rot} >> (N_PORTS - int'(rr_ptr_q)));
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < N_PORTS; k++)
            if (grant[k]) grant_idx = W_PTR'(k);
    end

    always_comb begin
        ahblm_haddr  = '0;
        ahblm_hwrite = 1'b0;
        ahblm_hsize  = '0;
        ahblm_hprot  = '0;
        ahblm_hexcl  = 1'b0;
        ahblm_hwdata = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (grant[k]) begin
                ahblm_haddr  = src_haddr[k*W_ADDR +: W_ADDR];
                ahblm_hwrite = src_hwrite[k];
                ahblm_hsize  = src_hsize[k*3 +: 3];
                ahblm_hprot  = src_hprot[k*4 +: 4];
                ahblm_hexcl  = src_aph_excl[k];
            end
            if (dph_owner_q[k])
                ahblm_hwdata = src_wdata[k*W_DATA +: W_DATA];
        end
    end

    assign ahblm_htrans    = (|grant) ? 2'b10 : 2'b00;
    assign ahblm_hburst    = 3'b000;
    assign ahblm_hmastlock = 1'b0;

    assign src_aph_ready  = {N_PORTS{ahblm_hready}}  & grant;
    assign src_dph_ready  = {N_PORTS{ahblm_hready}}  & dph_owner_q;
    assign src_dph_err    = {N_PORTS{ahblm_hresp}}   & dph_owner_q;
    assign src_dph_exokay = {N_PORTS{ahblm_hexokay}} & dph_owner_q;
    assign src_rdata      = ahblm_hrdata;

    // Hold drops on the first error cycle so the second error cycle may change winner or go IDLE.
    always_comb begin
        hold_d        = ahblm_htrans[1] && !ahblm_hready && !ahblm_hresp;
        grant_d       = grant;
        grant_panic_d = grant_panic;
        dph_owner_d   = ahblm_hready ? grant : dph_owner_q;
        rr_ptr_d      = rr_ptr_q;
        if (ahblm_hready && (|grant) && !grant_panic)
            rr_ptr_d = (grant_idx == W_PTR'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q        <= 1'b0;
            grant_panic_q <= 1'b0;
            grant_q       <= '0;
            dph_owner_q   <= '0;
            rr_ptr_q      <= '0;
        end else begin
            hold_q        <= hold_d;
            grant_panic_q <= grant_panic_d;
            grant_q       <= grant_d;
            dph_owner_q   <= dph_owner_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_hazard3_ahbl_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin arbiter share stimulus.
// A transaction-level model predicts each cycle's outputs, and a negedge monitor compares them.
module tb_hazard3_ahbl_arbiter;

    localparam int N  = 3;
    localparam int WA = 32;
    localparam int WD = 32;

    typedef struct {
        logic [N-1:0]  aph_ready;
        logic [N-1:0]  dph_ready;
        logic [N-1:0]  dph_err;
        logic [N-1:0]  dph_exokay;
        logic [WD-1:0] rdata;
        logic [WA-1:0] haddr;
        logic          hwrite;
        logic [1:0]    htrans;
        logic [2:0]    hsize;
        logic [2:0]    hburst;
        logic [3:0]    hprot;
        logic          hmastlock;
        logic          hexcl;
        logic [WD-1:0] hwdata;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src_aph_req, src_aph_panic, src_aph_excl, src_hwrite;
    logic [N*WA-1:0] src_haddr;
    logic [N*3-1:0]  src_hsize;
    logic [N*4-1:0]  src_hprot;
    logic [N*WD-1:0] src_wdata;
    logic            ahblm_hready, ahblm_hresp, ahblm_hexokay;
    logic [WD-1:0]   ahblm_hrdata;

    // Index 0: fixed priority, index 1: round-robin.
    logic [N-1:0]  aph_ready [2];
    logic [N-1:0]  dph_ready [2];
    logic [N-1:0]  dph_err   [2];
    logic [N-1:0]  dph_exokay[2];
    logic [WD-1:0] rdata     [2];
    logic [WA-1:0] haddr     [2];
    logic          hwrite    [2];
    logic [1:0]    htrans    [2];
    logic [2:0]    hsize     [2];
    logic [2:0]    hburst    [2];
    logic [3:0]    hprot     [2];
    logic          hmastlock [2];
    logic          hexcl     [2];
    logic [WD-1:0] hwdata    [2];

    for (genvar c = 0; c < 2; c++) begin : g_dut
        hazard3_ahbl_arbiter #(
            .N_PORTS(N), .W_ADDR(WA), .W_DATA(WD), .ROUND_ROBIN(c)
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .src_aph_req(src_aph_req), .src_aph_panic(src_aph_panic),
            .src_aph_excl(src_aph_excl), .src_haddr(src_haddr),
            .src_hsize(src_hsize), .src_hwrite(src_hwrite),
            .src_hprot(src_hprot), .src_wdata(src_wdata),
            .src_aph_ready(aph_ready[c]), .src_dph_ready(dph_ready[c]),
            .src_dph_err(dph_err[c]), .src_dph_exokay(dph_exokay[c]),
            .src_rdata(rdata[c]),
            .ahblm_haddr(haddr[c]), .ahblm_hwrite(hwrite[c]),
            .ahblm_htrans(htrans[c]), .ahblm_hsize(hsize[c]),
            .ahblm_hburst(hburst[c]), .ahblm_hprot(hprot[c]),
            .ahblm_hmastlock(hmastlock[c]), .ahblm_hexcl(hexcl[c]),
            .ahblm_hready(ahblm_hready), .ahblm_hresp(ahblm_hresp),
            .ahblm_hexokay(ahblm_hexokay), .ahblm_hwdata(hwdata[c]),
            .ahblm_hrdata(ahblm_hrdata)
        );
    end

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q_fp[$];
    exp_t q_rr[$];

    // Transaction-level model state: port indices, -1 meaning none.
    bit m_hold  [2] = '{0, 0};
    int m_prev_g[2] = '{-1, -1};
    bit m_prev_p[2] = '{0, 0};
    int m_rr    [2] = '{0, 0};
    int m_owner [2] = '{-1, -1};
    bit n_hold  [2];
    int n_prev_g[2];
    bit n_prev_p[2];
    int n_rr    [2];
    int n_owner [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_eval(input int cfg);
        exp_t e;
        int   g;
        int   o;
        bit   gp;
        g  = -1;
        gp = 1'b0;
        o  = m_owner[cfg];
        if (!rst_n) begin
            o = -1;
        end else if (m_hold[cfg]) begin
            g  = m_prev_g[cfg];
            gp = m_prev_p[cfg];
        end else if (src_aph_panic != 0) begin
            g  = lowest(src_aph_panic);
            gp = 1'b1;
        end else if (cfg == 0) begin
            g = lowest(src_aph_req);
        end else begin
            for (int i = 0; i < N; i++) begin
                int cand;
                cand = (m_rr[cfg] + i) % N;
                if (g < 0 && src_aph_req[cand]) g = cand;
            end
        end

        e = '{default: '0};
        e.rdata = ahblm_hrdata;
        if (g >= 0) begin
            e.htrans = 2'b10;
            e.haddr  = src_haddr[g*WA +: WA];
            e.hsize  = src_hsize[g*3 +: 3];
            e.hwrite = src_hwrite[g];
            e.hprot  = src_hprot[g*4 +: 4];
            e.hexcl  = src_aph_excl[g];
            if (ahblm_hready) e.aph_ready[g] = 1'b1;
        end
        if (o >= 0) begin
            if (ahblm_hready)  e.dph_ready[o]  = 1'b1;
            if (ahblm_hresp)   e.dph_err[o]    = 1'b1;
            if (ahblm_hexokay) e.dph_exokay[o] = 1'b1;
            e.hwdata = src_wdata[o*WD +: WD];
        end
        if (cfg == 0) q_fp.push_back(e);
        else          q_rr.push_back(e);

        if (!rst_n) begin
            n_hold[cfg] = 0; n_prev_g[cfg] = -1; n_prev_p[cfg] = 0;
            n_rr[cfg]   = 0; n_owner[cfg]  = -1;
        end else begin
            n_hold[cfg]   = (g >= 0) && !ahblm_hready && !ahblm_hresp;
            n_prev_g[cfg] = g;
            n_prev_p[cfg] = gp;
            n_rr[cfg]     = (ahblm_hready && g >= 0 && !gp) ? (g + 1) % N : m_rr[cfg];
            n_owner[cfg]  = ahblm_hready ? g : o;
        end
    endtask

    // Predict this cycle, then advance the model across the next rising edge.
    task automatic step();
        model_eval(0);
        model_eval(1);
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            m_hold[c] = n_hold[c]; m_prev_g[c] = n_prev_g[c]; m_prev_p[c] = n_prev_p[c];
            m_rr[c]   = n_rr[c];   m_owner[c]  = n_owner[c];
        end
        #1;
    endtask

    function automatic exp_t sample(input int c);
        exp_t a;
        a.aph_ready = aph_ready[c];  a.dph_ready  = dph_ready[c];
        a.dph_err   = dph_err[c];    a.dph_exokay = dph_exokay[c];
        a.rdata     = rdata[c];      a.haddr      = haddr[c];
        a.hwrite    = hwrite[c];     a.htrans     = htrans[c];
        a.hsize     = hsize[c];      a.hburst     = hburst[c];
        a.hprot     = hprot[c];      a.hmastlock  = hmastlock[c];
        a.hexcl     = hexcl[c];      a.hwdata     = hwdata[c];
        return a;
    endfunction

    task automatic compare(input string tag, input exp_t a, input exp_t e);
        check({tag, " aph_ready"},  64'(a.aph_ready),  64'(e.aph_ready));
        check({tag, " dph_ready"},  64'(a.dph_ready),  64'(e.dph_ready));
        check({tag, " dph_err"},    64'(a.dph_err),    64'(e.dph_err));
        check({tag, " dph_exokay"}, 64'(a.dph_exokay), 64'(e.dph_exokay));
        check({tag, " rdata"},      64'(a.rdata),      64'(e.rdata));
        check({tag, " haddr"},      64'(a.haddr),      64'(e.haddr));
        check({tag, " hwrite"},     64'(a.hwrite),     64'(e.hwrite));
        check({tag, " htrans"},     64'(a.htrans),     64'(e.htrans));
        check({tag, " hsize"},      64'(a.hsize),      64'(e.hsize));
        check({tag, " hburst"},     64'(a.hburst),     64'(e.hburst));
        check({tag, " hprot"},      64'(a.hprot),      64'(e.hprot));
        check({tag, " hmastlock"},  64'(a.hmastlock),  64'(e.hmastlock));
        check({tag, " hexcl"},      64'(a.hexcl),      64'(e.hexcl));
        check({tag, " hwdata"},     64'(a.hwdata),     64'(e.hwdata));
    endtask

    always @(negedge clk) begin
        if (q_fp.size() > 0) compare("fp", sample(0), q_fp.pop_front());
        if (q_rr.size() > 0) compare("rr", sample(1), q_rr.pop_front());
    end

    task automatic randomize_payload();
        for (int k = 0; k < N; k++) begin
            src_haddr[k*WA +: WA] = $urandom;
            src_wdata[k*WD +: WD] = $urandom;
            src_hsize[k*3 +: 3]   = 3'($urandom_range(0, 2));
            src_hprot[k*4 +: 4]   = 4'($urandom);
        end
        src_hwrite    = 3'($urandom);
        src_aph_excl  = 3'($urandom);
        ahblm_hrdata  = $urandom;
        ahblm_hexokay = 1'($urandom);
    endtask

    task automatic bus(input logic [N-1:0] req, input logic [N-1:0] pan,
                       input logic rdy, input logic resp);
        src_aph_req   = req;
        src_aph_panic = pan;
        ahblm_hready  = rdy;
        ahblm_hresp   = resp;
        step();
    endtask

    initial begin
        rst_n         = 1'b0;
        src_aph_req   = '0;
        src_aph_panic = '0;
        ahblm_hready  = 1'b1;
        ahblm_hresp   = 1'b0;
        randomize_payload();
        repeat (2) @(posedge clk);
        #1;
        bus(3'b111, 3'b000, 1'b1, 1'b0);            // requests held off by reset
        rst_n = 1'b1;

        // All ports request continuously: fixed stays on 0, round-robin rotates 0,1,2,0,1,2.
        repeat (6) bus(3'b111, 3'b000, 1'b1, 1'b0);

        // Port 1 stalls three cycles; port 0 joins in the second.
        bus(3'b000, 3'b000, 1'b1, 1'b0);
        bus(3'b010, 3'b000, 1'b0, 1'b0);
        bus(3'b011, 3'b000, 1'b0, 1'b0);
        bus(3'b011, 3'b000, 1'b0, 1'b0);
        bus(3'b011, 3'b000, 1'b1, 1'b0);
        bus(3'b001, 3'b000, 1'b1, 1'b0);

        // Port 2 write takes a two-cycle error response while port 0 requests.
        randomize_payload();
        src_hwrite = 3'b111;
        bus(3'b100, 3'b000, 1'b1, 1'b0);
        bus(3'b001, 3'b000, 1'b0, 1'b1);
        bus(3'b001, 3'b000, 1'b1, 1'b1);
        bus(3'b000, 3'b000, 1'b1, 1'b0);

        // Panic on port 2 with round-robin pointer at 1.
        rst_n = 1'b0;
        bus(3'b000, 3'b000, 1'b1, 1'b0);
        rst_n = 1'b1;
        bus(3'b001, 3'b000, 1'b1, 1'b0);
        bus(3'b111, 3'b100, 1'b1, 1'b0);
        bus(3'b011, 3'b000, 1'b1, 1'b0);

        // Reset cuts a stalled NSEQ with a data phase outstanding.
        bus(3'b001, 3'b000, 1'b1, 1'b0);
        bus(3'b010, 3'b000, 1'b0, 1'b0);
        bus(3'b010, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b0;
        bus(3'b010, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;
        bus(3'b110, 3'b000, 1'b1, 1'b0);
        bus(3'b111, 3'b000, 1'b1, 1'b0);

        // Random traffic with occasional panics, errors, stalls and resets.
        for (int i = 0; i < 400; i++) begin
            randomize_payload();
            rst_n = ($urandom_range(0, 99) != 0);
            bus(3'($urandom),
                ($urandom_range(0, 7) == 0) ? 3'(1 << $urandom_range(0, N - 1)) : 3'b000,
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0));
        end
        rst_n = 1'b1;

        @(negedge clk);
        #1;
        check("fp queue drained", 64'(q_fp.size()), 64'd0);
        check("rr queue drained", 64'(q_rr.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
